gpio_bus_bridge: RTL

Memory-mapped front end for the GPIO register block. It sits between the CPU's valid/ready data bus and the GPIO register's single-word port (wr_en, rd_en, wdata, rdata), and turns bus accesses into one-cycle enable pulses. The GPIO register's read data is registered with 1-cycle latency. The bridge also adds byte-strobe writes and atomic set/clear/toggle aliases, implemented as an internal read-modify-write sequence.

---
 rtl/gpio_bus_bridge.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/gpio_bus_bridge.sv
// Bridges the CPU valid/ready bus onto the GPIO register's single-word port,
// adding byte-strobe writes and SET/CLR/TGL aliases via read-modify-write.
module gpio_bus_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        gpio_wr_en,
  output logic        gpio_rd_en,
  output logic [31:0] gpio_wdata,
  input  logic [31:0] gpio_rdata
);

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned OW = 2;

  localparam logic [OW-1:0] OFF_DATA = OW'(0);
  localparam logic [OW-1:0] OFF_SET  = OW'(1);
  localparam logic [OW-1:0] OFF_CLR  = OW'(2);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t          r_state;
  logic [OW-1:0]   r_off;
  logic [DW-1:0]   r_wdata;
  logic [SW-1:0]   r_wstrb;
  logic            r_is_rd;
  logic [DW-1:0]   r_shadow;
  logic            r_mem_ready;
  logic [DW-1:0]   r_mem_rdata;
  logic            r_wr_en;
  logic            r_rd_en;
  logic [DW-1:0]   r_gpio_wdata;

  logic            w_hit;
  logic            w_is_rd;
  logic            w_rmw;
  logic [DW-1:0]   w_mask;
  logic [DW-1:0]   w_wm;
  logic [DW-1:0]   w_old;
  logic [DW-1:0]   w_merge;
  logic            w_unused;

  assign w_hit    = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign w_is_rd  = (mem_wstrb == SW'(0));
  assign w_rmw    = !w_is_rd && ((mem_addr[3:2] != OFF_DATA) || (mem_wstrb != {SW{1'b1}}));
  assign w_unused = ^mem_addr[1:0];

  assign w_mask = {{8{r_wstrb[3]}}, {8{r_wstrb[2]}}, {8{r_wstrb[1]}}, {8{r_wstrb[0]}}};
  assign w_wm   = r_wdata & w_mask;
  // Old value comes straight off gpio_rdata in WAIT so the merge is ready for WR
  assign w_old  = (r_state == S_WAIT) ? gpio_rdata : r_shadow;

  always_comb begin
    w_merge = w_old;
    case (r_off)
      OFF_DATA: w_merge = (w_old & ~w_mask) | w_wm;
      OFF_SET:  w_merge = w_old | w_wm;
      OFF_CLR:  w_merge = w_old & ~w_wm;
      default:  w_merge = w_old ^ w_wm;
    endcase
  end

  // Transaction sequencer; enables and ready are one-cycle registered pulses
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_off        <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_is_rd      <= 1'b0;
      r_shadow     <= '0;
      r_mem_ready  <= 1'b0;
      r_mem_rdata  <= '0;
      r_wr_en      <= 1'b0;
      r_rd_en      <= 1'b0;
      r_gpio_wdata <= '0;
    end else begin
      r_mem_ready <= 1'b0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_off   <= mem_addr[3:2];
            r_wdata <= mem_wdata;
            r_wstrb <= mem_wstrb;
            r_is_rd <= w_is_rd;
            if (w_is_rd || w_rmw) begin
              r_state <= S_RD;
              r_rd_en <= 1'b1;
            end else begin
              r_state      <= S_WR;
              r_wr_en      <= 1'b1;
              r_gpio_wdata <= mem_wdata;
            end
          end
        end
        S_RD: r_state <= S_WAIT;
        S_WAIT: begin
          r_shadow <= gpio_rdata;
          if (r_is_rd) begin
            r_mem_rdata <= gpio_rdata;
            r_mem_ready <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_wr_en      <= 1'b1;
            r_gpio_wdata <= w_merge;
            r_state      <= S_WR;
          end
        end
        S_WR: begin
          r_mem_ready <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_ready  = r_mem_ready;
  assign mem_rdata  = r_mem_rdata;
  assign gpio_wr_en = r_wr_en;
  assign gpio_rd_en = r_rd_en;
  assign gpio_wdata = r_gpio_wdata;

endmodule
